// File: rtl/ieee_fp_mult_seq.sv
// Sequential IEEE-style floating-point multiplier with an iterative shift-add significand datapath.
// Define FPMULT_FLAGS_EN to register {invalid, overflow, underflow, inexact}; otherwise flags read 0.
module ieee_fp_mult_seq #(
    parameter int MBITS = 3,
    parameter int EBITS = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MBITS+EBITS:0] x,
    input  logic [MBITS+EBITS:0] y,
    output logic                 busy,
    output logic                 done,
    output logic [MBITS+EBITS:0] z,
    output logic [3:0]           flags
);
    localparam int PW = 2*MBITS + 2;
    localparam int XW = EBITS + 2;
    localparam int CW = $clog2(MBITS + 1);
    localparam logic signed [XW-1:0] BIAS = XW'((1 << (EBITS-1)) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EBITS) - 1);
    localparam logic signed [XW-1:0] EMIN = '0;
    localparam logic signed [XW-1:0] EONE = XW'(1);

    typedef enum logic [1:0] {IDLE, MULT, PACK} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 xs, ys;
    logic [EBITS-1:0]     xe, ye;
    logic [MBITS-1:0]     xm, ym;
    logic [PW-1:0]        mcand, acc;
    logic [MBITS:0]       mplier;

    logic                 x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    logic                 is_nan, is_inf, is_zero, unf, ovf, g, st, sgn;
    logic signed [XW-1:0] e_sum, e_n, e_r;
    logic [MBITS-1:0]     m_n;
    logic [MBITS:0]       m_r;
    logic [MBITS+EBITS:0] res_z;

    // Round to nearest, ties to even; the extra MSB carries out of an all-ones mantissa.
    function automatic logic [MBITS:0] round_rne(input logic [MBITS-1:0] m,
                                                 input logic g_in, input logic s_in);
        return {1'b0, m} + {{MBITS{1'b0}}, g_in & (s_in | m[0])};
    endfunction

    function automatic logic [MBITS+EBITS:0] sat_inf(input logic s_in);
        return {s_in, {EBITS{1'b1}}, {MBITS{1'b0}}};
    endfunction

    always_comb begin
        x_zero  = (xe == '0);
        y_zero  = (ye == '0);
        x_inf   = (xe == '1) && (xm == '0);
        y_inf   = (ye == '1) && (ym == '0);
        x_nan   = (xe == '1) && (xm != '0);
        y_nan   = (ye == '1) && (ym != '0);
        sgn     = xs ^ ys;
        is_nan  = x_nan | y_nan | (x_inf & y_zero) | (y_inf & x_zero);
        is_inf  = x_inf | y_inf;
        is_zero = x_zero | y_zero;
        e_sum   = signed'({2'b00, xe}) + signed'({2'b00, ye}) - BIAS;
        if (acc[PW-1]) begin
            m_n = acc[PW-2 -: MBITS];
            g   = acc[MBITS];
            st  = |acc[MBITS-1:0];
            e_n = e_sum + EONE;
        end else begin
            m_n = acc[PW-3 -: MBITS];
            g   = acc[MBITS-1];
            st  = |acc[MBITS-2:0];
            e_n = e_sum;
        end
        m_r = round_rne(m_n, g, st);
        e_r = m_r[MBITS] ? e_n + EONE : e_n;
        unf = (e_r <= EMIN);
        ovf = !unf && (e_r >= EMAX);
        if (is_nan)
            res_z = {1'b0, {EBITS{1'b1}}, {MBITS{1'b1}}};
        else if (is_inf)
            res_z = sat_inf(sgn);
        else if (is_zero || unf)
            res_z = {sgn, {(MBITS+EBITS){1'b0}}};
        else if (ovf)
            res_z = sat_inf(sgn);
        else
            res_z = {sgn, e_r[EBITS-1:0], m_r[MBITS-1:0]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            z     <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        xs     <= x[MBITS+EBITS];
                        ys     <= y[MBITS+EBITS];
                        xe     <= x[MBITS+EBITS-1 -: EBITS];
                        ye     <= y[MBITS+EBITS-1 -: EBITS];
                        xm     <= x[MBITS-1:0];
                        ym     <= y[MBITS-1:0];
                        mcand  <= PW'({|x[MBITS+EBITS-1 -: EBITS], x[MBITS-1:0]});
                        mplier <= {|y[MBITS+EBITS-1 -: EBITS], y[MBITS-1:0]};
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= MULT;
                    end
                end
                // one multiplier bit per cycle, LSB first
                MULT: begin
                    acc    <= acc + (mplier[0] ? mcand : '0);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(MBITS))
                        state <= PACK;
                end
                PACK: begin
                    z     <= res_z;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FPMULT_FLAGS_EN
    logic [3:0] flags_q, res_flags;
    logic       regular;

    always_comb begin
        regular   = !is_nan && !is_inf && !is_zero;
        res_flags = {is_nan, regular & ovf, regular & unf, regular & (g | st | unf | ovf)};
    end

    always_ff @(posedge clock) begin
        if (reset)
            flags_q <= 4'b0000;
        else if (state == IDLE && start)
            flags_q <= 4'b0000;
        else if (state == PACK)
            flags_q <= res_flags;
    end

    assign flags = flags_q;
`else
    assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_ieee_fp_mult_seq.sv
// Scoreboard bench for ieee_fp_mult_seq at MBITS=3, EBITS=4 (bias 7) with hand-computed vectors.
module tb_ieee_fp_mult_seq;
    localparam int MB = 3;
    localparam int EB = 4;
`ifdef FPMULT_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] x = '0;
    logic [7:0] y = '0;
    logic       busy, done;
    logic [7:0] z;
    logic [3:0] flags;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ez;
        logic [3:0] ef;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_v;
    int   checks = 0;
    int   errors = 0;

    ieee_fp_mult_seq #(.MBITS(MB), .EBITS(EB)) dut (
        .clock(clock), .reset(reset), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .z(z), .flags(flags)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every done pulse must match the oldest accepted operation.
    always @(negedge clock) begin
        if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done actual z=%h flags=%b required no done", z, flags);
            end else begin
                exp_v = exp_q.pop_front();
                if (z !== exp_v.ez || flags !== exp_v.ef) begin
                    errors++;
                    $display("FAIL result %h*%h actual z=%h flags=%b required z=%h flags=%b",
                             exp_v.a, exp_v.b, z, flags, exp_v.ez, exp_v.ef);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_res(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] ez, input logic [3:0] ef);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.ez = ez;
        e.ef = FLAGS_ON ? ef : 4'b0000;
        exp_q.push_back(e);
    endtask

    // Called at a negedge with the DUT idle; start is accepted at the next posedge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ez, input logic [3:0] ef);
        int   cyc;
        logic busy_gap;
        x = a;
        y = b;
        start = 1'b1;
        expect_res(a, b, ez, ef);
        @(posedge clock);
        #1;
        start = 1'b0;
        x = 8'($urandom);
        y = 8'($urandom);
        cyc = 0;
        busy_gap = 1'b0;
        forever begin
            @(negedge clock);
            if (done || cyc >= 50) break;
            if (!busy) busy_gap = 1'b1;
            cyc++;
        end
        chk("latency", cyc, MB + 2);
        chk("busy_held", busy_gap, 1'b0);
        chk("busy_at_done", busy, 1'b0);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ez, input logic [3:0] ef);
        @(negedge clock);
        launch(a, b, ez, ef);
    endtask

    task automatic back_to_back();
        logic [7:0] bx[4] = '{8'h3C, 8'hBC, 8'h39, 8'h3D};
        logic [7:0] by[4] = '{8'h3C, 8'h3C, 8'h3C, 8'h39};
        logic [7:0] bz[4] = '{8'h41, 8'hC1, 8'h3E, 8'h3F};
        logic [3:0] bf[4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001};
        int idx, gap, guard;
        @(negedge clock);
        x = bx[0];
        y = by[0];
        start = 1'b1;
        expect_res(bx[0], by[0], bz[0], bf[0]);
        idx = 1;
        gap = 0;
        guard = 0;
        while (guard < 200) begin
            @(negedge clock);
            guard++;
            gap++;
            if (done) begin
                chk("b2b_period", gap, MB + 3);
                gap = 0;
                if (idx < 4) begin
                    x = bx[idx];
                    y = by[idx];
                    expect_res(bx[idx], by[idx], bz[idx], bf[idx]);
                    idx++;
                end else begin
                    start = 1'b0;
                    break;
                end
            end else begin
                x = 8'($urandom);
                y = 8'($urandom);
            end
        end
        chk("b2b_completed", guard < 200, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_z", z, 8'h00);
        chk("reset_flags", flags, 4'b0000);
        reset = 1'b0;

        run_op(8'h3C, 8'h3C, 8'h41, 4'b0000);
        run_op(8'h3A, 8'h3A, 8'h3C, 4'b0001);
        run_op(8'h39, 8'h39, 8'h3A, 4'b0001);
        run_op(8'h39, 8'h3C, 8'h3E, 4'b0001);
        run_op(8'h3D, 8'h39, 8'h3F, 4'b0001);
        run_op(8'h39, 8'h3E, 8'h40, 4'b0001);
        run_op(8'h3F, 8'h39, 8'h40, 4'b0001);
        run_op(8'h77, 8'h77, 8'h78, 4'b0101);
        run_op(8'h71, 8'h3E, 8'h78, 4'b0101);
        run_op(8'h71, 8'h38, 8'h71, 4'b0000);
        run_op(8'h08, 8'h08, 8'h00, 4'b0011);
        run_op(8'h08, 8'h38, 8'h08, 4'b0000);
        run_op(8'h08, 8'h30, 8'h00, 4'b0011);
        run_op(8'h88, 8'h30, 8'h80, 4'b0011);
        run_op(8'h78, 8'h00, 8'h7F, 4'b1000);
        run_op(8'h7A, 8'h38, 8'h7F, 4'b1000);
        run_op(8'h78, 8'hC0, 8'hF8, 4'b0000);
        run_op(8'h38, 8'hB8, 8'hB8, 4'b0000);
        run_op(8'h00, 8'hB8, 8'h80, 4'b0000);
        run_op(8'h05, 8'h38, 8'h00, 4'b0000);
        run_op(8'hBC, 8'h3C, 8'hC1, 4'b0000);

        back_to_back();

        // Abandon an operation with reset two edges after acceptance.
        @(negedge clock);
        x = 8'h3C;
        y = 8'h3C;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_z", z, 8'h00);
        chk("rst_mid_flags", flags, 4'b0000);
        reset = 1'b0;
        launch(8'h39, 8'h3C, 8'h3E, 4'b0001);

        // Reset and start on the same edge: start must not be accepted.
        @(negedge clock);
        reset = 1'b1;
        start = 1'b1;
        x = 8'h3C;
        y = 8'h3C;
        @(negedge clock);
        chk("rst_start_busy", busy, 1'b0);
        chk("rst_start_z", z, 8'h00);
        reset = 1'b0;
        start = 1'b0;
        repeat (8) @(negedge clock);
        chk("rst_start_idle", busy, 1'b0);

        repeat (3) @(negedge clock);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
